// File: rtl/sha256_spi_pkg.sv
// Frame layout and host FSM encoding shared by the SPI host and the slave-side frame decode.
// Combinational helpers only; carries no state or flow control.
package sha256_spi_pkg;

   localparam int FRAME_W  = 16;
   localparam int ADDR_W   = 7;
   localparam int DATA_W   = 8;
   localparam int RW_BIT   = 15;
   localparam int ADDR_MSB = 14;
   localparam int ADDR_LSB = 8;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } spi_state_t;

   function automatic logic [FRAME_W-1:0] pack_frame(
      input logic              wr,
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] data
   );
      logic [FRAME_W-1:0] f;
      f                    = '0;
      f[RW_BIT]            = wr;
      f[ADDR_MSB:ADDR_LSB] = addr;
      f[ADDR_LSB-1:0]      = data;
      return f;
   endfunction

endpackage

// File: rtl/sha256_spi_sck_gen.sv
// SCK generator: half-period counter, registered SCK (idle high), fall/rise strobes and terminal count.
// Strobes flag the edge on which SCK changes; no backpressure, counting simply stops when en drops.
module sha256_spi_sck_gen #(
   parameter int CLK_DIV = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic toggle,
   output logic sck,
   output logic tc,
   output logic fall,
   output logic rise
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tc   = en && (cnt == CNT_MAX);
   assign fall = tc && toggle && sck;
   assign rise = tc && toggle && !sck;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         sck <= 1'b1;
      end else if (!en) begin
         cnt <= '0;
         sck <= 1'b1;
      end else begin
         cnt <= tc ? '0 : cnt + CW'(1);
         if (tc && toggle) begin
            sck <= ~sck;
         end
      end
   end

endmodule

// File: rtl/sha256_spi_host.sv
// SPI mode-3 master issuing one 16-bit R/W/addr/data frame per accepted request, returning the MISO word.
// 34*CLK_DIV cycles from acceptance to o_rvalid; requests are dropped while o_busy is high.
module sha256_spi_host
   import sha256_spi_pkg::*;
#(
   parameter int CLK_DIV = 8,
   parameter int SS_GAP  = 4
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_req,
   input  logic               i_wr,
   input  logic [ADDR_W-1:0]  i_addr,
   input  logic [DATA_W-1:0]  i_wdata,
   output logic               o_busy,
   output logic               o_rvalid,
   output logic [FRAME_W-1:0] o_rdata,
   output logic               o_sck,
   output logic               o_ss_n,
   output logic               o_mosi,
   input  logic               i_miso
);

   // The slave sees SCK through a 3-flop synchroniser, so a half-period shorter than 4 is unsafe.
   if (CLK_DIV < 4) begin : g_div_chk
      $error("sha256_spi_host: CLK_DIV must be at least 4");
   end
   if (SS_GAP < 1) begin : g_gap_chk
      $error("sha256_spi_host: SS_GAP must be at least 1");
   end

   localparam int GW = $clog2(SS_GAP + 1);
   localparam logic [GW-1:0] GAP_MAX = GW'(SS_GAP - 1);

   spi_state_t         state;
   logic [FRAME_W-1:0] tx_sr;
   logic [FRAME_W-1:0] rx_sr;
   logic [3:0]         bit_cnt;
   logic [GW-1:0]      gap_cnt;

   logic gen_en;
   logic gen_tog;
   logic sck_tc;
   logic sck_fall;
   logic sck_rise;
   logic last_half;

   // bit_cnt counts rises and wraps to 0 on the 16th; SCK high with a zero count is the final high half.
   assign last_half = (state == SHIFT) && o_sck && (bit_cnt == 4'd0);
   assign gen_en    = (state == SETUP) || (state == SHIFT) || (state == HOLD);
   assign gen_tog   = (state == SETUP) || ((state == SHIFT) && !last_half);

   sha256_spi_sck_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_sck_gen (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .en     (gen_en),
      .toggle (gen_tog),
      .sck    (o_sck),
      .tc     (sck_tc),
      .fall   (sck_fall),
      .rise   (sck_rise)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         tx_sr    <= '0;
         rx_sr    <= '0;
         bit_cnt  <= '0;
         gap_cnt  <= '0;
         o_busy   <= 1'b0;
         o_rvalid <= 1'b0;
         o_rdata  <= '0;
         o_ss_n   <= 1'b1;
         o_mosi   <= 1'b0;
      end else begin
         o_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (i_req) begin
                  tx_sr   <= pack_frame(i_wr, i_addr, i_wdata);
                  bit_cnt <= '0;
                  o_busy  <= 1'b1;
                  o_ss_n  <= 1'b0;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               if (sck_tc) begin
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (sck_rise) begin
                  rx_sr   <= {rx_sr[FRAME_W-2:0], i_miso};
                  bit_cnt <= (bit_cnt == 4'd15) ? 4'd0 : bit_cnt + 4'd1;
               end
               if (sck_tc && last_half) begin
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (sck_tc) begin
                  o_ss_n   <= 1'b1;
                  o_rdata  <= rx_sr;
                  o_rvalid <= 1'b1;
                  o_mosi   <= 1'b0;
                  gap_cnt  <= '0;
                  state    <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_MAX) begin
                  gap_cnt <= '0;
                  o_busy  <= 1'b0;
                  state   <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
         // Leading (falling) edge launches the next MOSI bit.
         if (sck_fall) begin
            o_mosi <= tx_sr[FRAME_W-1];
            tx_sr  <= {tx_sr[FRAME_W-2:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_sha256_spi_host.sv
// Directed bench for sha256_spi_host with a mode-3 register-slave model on the SPI pins.
module tb_sha256_spi_host;

   logic        i_clk   = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_req   = 1'b0;
   logic        i_wr    = 1'b0;
   logic [6:0]  i_addr  = '0;
   logic [7:0]  i_wdata = '0;
   logic        i_miso  = 1'b0;
   logic        o_busy;
   logic        o_rvalid;
   logic [15:0] o_rdata;
   logic        o_sck;
   logic        o_ss_n;
   logic        o_mosi;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rv_cnt   = 0;

   sha256_spi_host #(
      .CLK_DIV(8),
      .SS_GAP (4)
   ) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_req   (i_req),
      .i_wr    (i_wr),
      .i_addr  (i_addr),
      .i_wdata (i_wdata),
      .o_busy  (o_busy),
      .o_rvalid(o_rvalid),
      .o_rdata (o_rdata),
      .o_sck   (o_sck),
      .o_ss_n  (o_ss_n),
      .o_mosi  (o_mosi),
      .i_miso  (i_miso)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;
   always @(posedge i_clk) if (o_rvalid === 1'b1) rv_cnt <= rv_cnt + 1;

   // Slave model: register file, read data returned in the frame after the read command.
   logic [7:0]  regs [128] = '{default: 8'h00};
   logic [15:0] resp_next  = 16'h0000;
   logic [15:0] resp_force = 16'h0000;
   logic        force_en   = 1'b0;
   logic [15:0] miso_sh    = 16'h0000;
   logic [15:0] mosi_word  = 16'h0000;
   logic [15:0] last_frame = 16'h0000;
   logic        ss_q       = 1'b1;
   logic        sck_q      = 1'b1;
   int          frames     = 0;
   int          rise_cnt   = 0;
   int          fall_cnt   = 0;

   always @(o_ss_n or o_sck) begin
      if (ss_q === 1'b1 && o_ss_n === 1'b0) begin
         frames    = frames + 1;
         miso_sh   = force_en ? resp_force : resp_next;
         mosi_word = 16'h0000;
         rise_cnt  = 0;
         fall_cnt  = 0;
      end else if (ss_q === 1'b0 && o_ss_n === 1'b1) begin
         if (rise_cnt == 16) begin
            last_frame = mosi_word;
            if (mosi_word[15]) begin
               regs[mosi_word[14:8]] = mosi_word[7:0];
               resp_next = 16'h0000;
            end else begin
               resp_next = {1'b0, mosi_word[14:8], regs[mosi_word[14:8]]};
            end
         end
      end else if (o_ss_n === 1'b0 && sck_q === 1'b1 && o_sck === 1'b0) begin
         fall_cnt = fall_cnt + 1;
         i_miso   = miso_sh[15];
         miso_sh  = {miso_sh[14:0], 1'b0};
      end else if (o_ss_n === 1'b0 && sck_q === 1'b0 && o_sck === 1'b1) begin
         rise_cnt  = rise_cnt + 1;
         mosi_word = {mosi_word[14:0], o_mosi};
      end
      ss_q  = o_ss_n;
      sck_q = o_sck;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One request pulse; inputs are scrambled after acceptance to show only latched values matter.
   task automatic do_frame(input logic wr, input logic [6:0] a, input logic [7:0] d,
                           output int lat, output logic [15:0] rd);
      int t_acc;
      bit got;
      @(negedge i_clk);
      i_wr = wr; i_addr = a; i_wdata = d; i_req = 1'b1;
      @(negedge i_clk);
      i_req = 1'b0;
      t_acc = cyc;
      i_wr = ~wr; i_addr = ~a; i_wdata = ~d;
      got = 1'b0;
      lat = -1;
      rd  = 16'hxxxx;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge i_clk);
         if (o_rvalid === 1'b1) begin
            got = 1'b1;
            lat = cyc - t_acc;
            rd  = o_rdata;
         end
      end
      chk("rvalid_seen", {31'd0, got}, 32'd1);
      for (int i = 0; i < 20 && o_busy !== 1'b0; i++) @(negedge i_clk);
   endtask

   initial begin
      int          lat;
      logic [15:0] rd;
      logic [15:0] rd1;
      int          t_rv [3];
      int          gaps [2];
      int          nrv;
      int          ng;
      int          hi_run;
      bit          seen_low;
      int          f0;
      int          r0;

      // Reset state
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("rst_sck",    {31'd0, o_sck},    32'd1);
      chk("rst_ss_n",   {31'd0, o_ss_n},   32'd1);
      chk("rst_mosi",   {31'd0, o_mosi},   32'd0);
      chk("rst_busy",   {31'd0, o_busy},   32'd0);
      chk("rst_rvalid", {31'd0, o_rvalid}, 32'd0);
      chk("rst_rdata",  {16'd0, o_rdata},  32'h0000);

      // Write frame
      do_frame(1'b1, 7'h05, 8'hA5, lat, rd);
      chk("wr_latency", lat, 32'd272);
      chk("wr_mosi",    {16'd0, last_frame}, 32'h85A5);
      chk("wr_rises",   rise_cnt, 32'd16);
      chk("wr_falls",   fall_cnt, 32'd16);

      // Read frame with a forced MISO word
      resp_force = 16'h20C3;
      force_en   = 1'b1;
      do_frame(1'b0, 7'h20, 8'h00, lat, rd);
      force_en   = 1'b0;
      chk("rd_rdata", {16'd0, rd}, 32'h20C3);
      chk("rd_mosi",  {16'd0, last_frame}, 32'h2000);
      repeat (10) @(negedge i_clk);
      chk("rd_held",  {16'd0, o_rdata}, 32'h20C3);

      // Back-to-back with i_req held high
      @(negedge i_clk);
      i_wr = 1'b1; i_addr = 7'h0A; i_wdata = 8'h55; i_req = 1'b1;
      nrv = 0; ng = 0; hi_run = 0; seen_low = 1'b0;
      for (int i = 0; i < 1200 && nrv < 3; i++) begin
         @(negedge i_clk);
         if (o_rvalid === 1'b1) begin
            t_rv[nrv] = cyc;
            nrv++;
            if (nrv == 3) i_req = 1'b0;
         end
         if (o_ss_n === 1'b1) begin
            hi_run++;
         end else begin
            if (seen_low && hi_run > 0 && ng < 2) begin
               gaps[ng] = hi_run;
               ng++;
            end
            seen_low = 1'b1;
            hi_run   = 0;
         end
      end
      i_req = 1'b0;
      chk("b2b_pulses",  nrv, 32'd3);
      chk("b2b_space01", t_rv[1] - t_rv[0], 32'd277);
      chk("b2b_space12", t_rv[2] - t_rv[1], 32'd277);
      chk("b2b_gap0",    gaps[0], 32'd5);
      chk("b2b_gap1",    gaps[1], 32'd5);
      for (int i = 0; i < 20 && o_busy !== 1'b0; i++) @(negedge i_clk);

      // Request while busy is dropped
      f0 = frames;
      r0 = rv_cnt;
      @(negedge i_clk);
      i_wr = 1'b0; i_addr = 7'h01; i_req = 1'b1;
      @(negedge i_clk);
      i_req = 1'b0;
      repeat (48) @(negedge i_clk);
      i_req = 1'b1;
      @(negedge i_clk);
      i_req = 1'b0;
      for (int i = 0; i < 400 && o_busy !== 1'b0; i++) @(negedge i_clk);
      repeat (20) @(negedge i_clk);
      chk("busy_frames", frames - f0, 32'd1);
      chk("busy_rvalid", rv_cnt - r0, 32'd1);

      // Reset after the 7th rising edge
      r0 = rv_cnt;
      @(negedge i_clk);
      i_wr = 1'b1; i_addr = 7'h33; i_wdata = 8'hFF; i_req = 1'b1;
      @(negedge i_clk);
      i_req = 1'b0;
      for (int i = 0; i < 300 && rise_cnt < 7; i++) @(negedge i_clk);
      chk("abort_rise7", rise_cnt, 32'd7);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b0;
      #1;
      chk("abort_ss_n",   {31'd0, o_ss_n},   32'd1);
      chk("abort_sck",    {31'd0, o_sck},    32'd1);
      chk("abort_busy",   {31'd0, o_busy},   32'd0);
      chk("abort_mosi",   {31'd0, o_mosi},   32'd0);
      chk("abort_rvalid", {31'd0, o_rvalid}, 32'd0);
      chk("abort_rdata",  {16'd0, o_rdata},  32'h0000);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      repeat (300) @(negedge i_clk);
      chk("abort_no_rvalid", rv_cnt - r0, 32'd0);
      do_frame(1'b1, 7'h11, 8'h3C, lat, rd);
      chk("post_abort_lat",   lat, 32'd272);
      chk("post_abort_mosi",  {16'd0, last_frame}, 32'h913C);
      chk("post_abort_rises", rise_cnt, 32'd16);

      // End-to-end: write then two reads of the same register
      do_frame(1'b1, 7'h00, 8'h61, lat, rd);
      do_frame(1'b0, 7'h00, 8'h00, lat, rd1);
      do_frame(1'b0, 7'h00, 8'h00, lat, rd);
      chk("e2e_first_read",  {16'd0, rd1}, 32'h0000);
      chk("e2e_second_read", {24'd0, rd[7:0]}, 32'h61);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
